// File: rtl/repetition_pkg.sv
// Shared types and default widths for the repetition sequence monitor.
// Holds no logic of its own: only enums and width constants.
package repetition_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int TO_W_DEF  = 8;
  localparam int MC_W_DEF  = 16;

  typedef enum logic {
    CONSECUTIVE = 1'b0,
    GOTO        = 1'b1
  } rep_kind_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; sync clear wins over enable.
// One-cycle update latency; no handshake, it counts whenever enabled.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/repetition_seq_monitor.sv
// Runtime-configurable matcher for a[*N] and a ##1 b[->N]; registered match/fail pulses, 1-cycle latency.
// Config is accepted only in IDLE (cfg_ready); stop aborts an attempt without pulsing.
module repetition_seq_monitor
  import repetition_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TO_W  = TO_W_DEF,
  parameter int MC_W  = MC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_kind,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             stop,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             match,
  output logic             fail,
  output logic [MC_W-1:0]  match_count
);

  state_e           state_q, state_d;
  rep_kind_e        kind_q;
  logic [CNT_W-1:0] n_q;
  logic [TO_W-1:0]  to_q;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             match_d, fail_d, load_cfg;
  logic [TO_W-1:0]  timer;
  logic             timer_clr;
  logic             last_rep, timed_out;

  assign last_rep  = (rep_q == n_q - CNT_W'(1));
  // timer holds edges-since-trigger minus one, so this fires on edge k+to_q
  assign timed_out = (to_q != '0) && (timer == to_q - TO_W'(1));

  always_comb begin
    state_d  = state_q;
    rep_d    = rep_q;
    match_d  = 1'b0;
    fail_d   = 1'b0;
    load_cfg = 1'b0;
    if (stop) begin
      state_d = IDLE;
      rep_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            load_cfg = 1'b1;
            state_d  = ARMED;
            rep_d    = '0;
          end
        end
        ARMED: begin
          if (kind_q == CONSECUTIVE) begin
            if (!a) begin
              rep_d = '0;
            end else if (last_rep) begin
              match_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + CNT_W'(1);
            end
          end else if (a) begin
            state_d = COUNT;
            rep_d   = '0;
          end
        end
        COUNT: begin
          if (b && last_rep) begin
            match_d = 1'b1;
            state_d = ARMED;
            rep_d   = '0;
          end else if (timed_out) begin
            fail_d  = 1'b1;
            state_d = ARMED;
            rep_d   = '0;
          end else if (b) begin
            rep_d = rep_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rep_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rep_q   <= '0;
      match   <= 1'b0;
      fail    <= 1'b0;
      kind_q  <= CONSECUTIVE;
      n_q     <= CNT_W'(1);
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      match   <= match_d;
      fail    <= fail_d;
      if (load_cfg) begin
        kind_q <= rep_kind_e'(cfg_kind);
        n_q    <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
        to_q   <= cfg_timeout;
      end
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // timer restarts on entry to COUNT and idles at zero elsewhere
  assign timer_clr = (state_q != COUNT) || (state_d != COUNT);

  sat_counter #(.WIDTH(TO_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (1'b1),
    .q   (timer)
  );

  sat_counter #(.WIDTH(MC_W)) u_match_count (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (match_d),
    .q   (match_count)
  );

endmodule
